// File: rtl/imem_boot_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake from the UART receiver into the boot loader.
interface imem_boot_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/imem_boot_loader_rx_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; used for both the
// length header and the program data words.
module rx_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        last
);

  logic [LANE_W-1:0] byte_cnt;

  function automatic logic [31:0] insert_lane(input logic [31:0] w,
                                              input logic [LANE_W-1:0] lane,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*lane +: 8] = b;
    return r;
  endfunction

  // word_next already holds the completed word on the strobe cycle, so the
  // header length can be captured without waiting for the register.
  assign word_next = insert_lane(word, byte_cnt, data);
  assign last      = shift && (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (clear)
      byte_cnt <= '0;
    else if (shift)
      byte_cnt <= byte_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (shift)
      word <= word_next;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream into instruction memory while holding the core
// in reset, then hands the memory address port to the core PC.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int SIZE  = 1024,
  parameter int IDX_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_boot_loader_if.slave    rx,
  input  logic                 load_start,
  input  logic [31:0]          core_a,
  output logic [31:0]          mem_a,
  output logic [31:0]          mem_wd,
  output logic                 mem_we,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W:0]       words_loaded
);

  state_t             state, state_next;
  logic [31:0]        len;
  logic [IDX_W-1:0]   widx;
  logic [7:0]         csum;
  logic               accept;
  logic               pk_shift;
  logic               pk_last;
  logic [31:0]        pk_word;
  logic [31:0]        pk_word_next;
  logic               len_ok;
  logic               last_word;
  logic [31:0]        widx_addr;

  assign accept    = rx.rx_valid && rx.rx_ready;
  assign pk_shift  = accept && (state == HDR || state == DATA);
  assign len_ok    = (pk_word_next >= 32'd1) && (pk_word_next <= 32'(SIZE));
  // Decided on the pre-increment index so N == SIZE never sees widx wrap.
  assign last_word = ({{(32-IDX_W){1'b0}}, widx} == (len - 32'd1));
  assign widx_addr = {{(32-IDX_W-2){1'b0}}, widx, 2'b00};

  rx_word_packer u_packer (
    .clk       (clk),
    .clear     (!reset),
    .shift     (pk_shift),
    .data      (rx.rx_data),
    .word      (pk_word),
    .word_next (pk_word_next),
    .last      (pk_last)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= HDR;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR:   if (pk_last) state_next = len_ok ? DATA : ERR;
      DATA:  if (pk_last) state_next = WRITE;
      WRITE: state_next = last_word ? CSUM : DATA;
      CSUM:  if (accept) state_next = (rx.rx_data == csum) ? RUN : ERR;
      RUN,
      ERR:   if (load_start) state_next = HDR;
      default: state_next = HDR;
    endcase
  end

  // Counters, checksum and the registered core reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len          <= '0;
      widx         <= '0;
      csum         <= '0;
      words_loaded <= '0;
      core_rst_n   <= 1'b0;
    end else begin
      core_rst_n <= (state_next == RUN);
      case (state)
        HDR: begin
          if (pk_last) begin
            len          <= pk_word_next;
            widx         <= '0;
            csum         <= '0;
            words_loaded <= '0;
          end
        end
        DATA: begin
          if (accept)
            csum <= csum ^ rx.rx_data;
        end
        WRITE: begin
          widx         <= widx + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx.rx_ready = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    if (!reset) begin
      busy = 1'b1;
    end else begin
      case (state)
        HDR, DATA, CSUM: begin
          rx.rx_ready = 1'b1;
          busy        = 1'b1;
          mem_a       = widx_addr;
        end
        WRITE: begin
          busy   = 1'b1;
          mem_we = 1'b1;
          mem_a  = widx_addr;
          mem_wd = pk_word;
        end
        RUN: begin
          done  = 1'b1;
          mem_a = core_a;
        end
        ERR: begin
          err = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames are streamed byte by byte and
// memory writes are logged for comparison against hand-computed values.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [31:0] core_a;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  imem_boot_loader_if rif ();

  imem_boot_loader #(.SIZE(1024), .IDX_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rif),
    .load_start   (load_start),
    .core_a       (core_a),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] frame[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         bp_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mem_we === 1'b1)
        wlog.push_back(wr_t'{a: mem_a, d: mem_wd});
      if (bp_mode && busy === 1'b1)
        check("ready_vs_write", {31'b0, rif.rx_ready}, {31'b0, ~mem_we});
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    int  n;
    bit  acc;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rif.rx_data  = b;
    rif.rx_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = rif.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rif.rx_valid = 1'b0;
    if (!acc)
      check("rx_accept_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i])
      send_byte(frame[i], max_gap);
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    load_start   = 1'b0;
    core_a       = 32'h0000_0123;
    rif.rx_valid = 1'b0;
    rif.rx_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready",   {31'b0, rif.rx_ready}, 32'd0);
    check("rst_mem_we",     {31'b0, mem_we},       32'd0);
    check("rst_mem_a",      mem_a,                 32'd0);
    check("rst_mem_wd",     mem_wd,                32'd0);
    check("rst_busy",       {31'b0, busy},         32'd1);
    check("rst_done",       {31'b0, done},         32'd0);
    check("rst_err",        {31'b0, err},          32'd0);
    check("rst_core_rst_n", {31'b0, core_rst_n},   32'd0);
    check("rst_words",      {21'b0, words_loaded}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("hdr_rx_ready", {31'b0, rif.rx_ready}, 32'd1);

    // Two-word load; checksum is the XOR of the eight data bytes = 0x2A
    wlog.delete();
    core_a = 32'h0;
    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_frame(0);
    check("l2_done",       {31'b0, done},         32'd1);
    check("l2_core_rst_n", {31'b0, core_rst_n},   32'd1);
    check("l2_err",        {31'b0, err},          32'd0);
    check("l2_busy",       {31'b0, busy},         32'd0);
    check("l2_rx_ready",   {31'b0, rif.rx_ready}, 32'd0);
    check("l2_words",      {21'b0, words_loaded}, 32'd2);
    check("l2_nwrites",    wlog.size(),           32'd2);
    check("l2_w0_a",       wlog[0].a,             32'h0);
    check("l2_w0_d",       wlog[0].d,             32'h1234_5678);
    check("l2_w1_a",       wlog[1].a,             32'h4);
    check("l2_w1_d",       wlog[1].d,             32'hDEAD_BEEF);
    core_a = 32'h8;
    #1;
    check("run_mem_a",  mem_a,            32'h8);
    check("run_mem_we", {31'b0, mem_we},  32'd0);
    check("run_mem_wd", mem_wd,           32'd0);

    // Reload from RUN with a one-word frame
    pulse_load();
    check("rl_core_rst_n", {31'b0, core_rst_n},   32'd0);
    check("rl_busy",       {31'b0, busy},         32'd1);
    check("rl_done",       {31'b0, done},         32'd0);
    check("rl_rx_ready",   {31'b0, rif.rx_ready}, 32'd1);
    pulse_load();
    check("rl_ignored_busy", {31'b0, busy}, 32'd1);
    check("rl_ignored_err",  {31'b0, err},  32'd0);
    wlog.delete();
    frame = {8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame(0);
    check("l1_done",       {31'b0, done},         32'd1);
    check("l1_core_rst_n", {31'b0, core_rst_n},   32'd1);
    check("l1_words",      {21'b0, words_loaded}, 32'd1);
    check("l1_nwrites",    wlog.size(),           32'd1);
    check("l1_w0_a",       wlog[0].a,             32'h0);
    check("l1_w0_d",       wlog[0].d,             32'h0000_0013);

    // Bad checksum
    pulse_load();
    wlog.delete();
    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    send_frame(0);
    repeat (3) @(posedge clk);
    #1;
    check("bc_err",        {31'b0, err},          32'd1);
    check("bc_done",       {31'b0, done},         32'd0);
    check("bc_busy",       {31'b0, busy},         32'd0);
    check("bc_core_rst_n", {31'b0, core_rst_n},   32'd0);
    check("bc_rx_ready",   {31'b0, rif.rx_ready}, 32'd0);
    check("bc_mem_a",      mem_a,                 32'd0);
    check("bc_nwrites",    wlog.size(),           32'd2);
    pulse_load();
    check("bc_restart_ready", {31'b0, rif.rx_ready}, 32'd1);
    check("bc_restart_err",   {31'b0, err},          32'd0);
    check("bc_restart_busy",  {31'b0, busy},         32'd1);

    // Illegal lengths: N = 0 and N = SIZE + 1
    wlog.delete();
    frame = {8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("n0_err",     {31'b0, err},          32'd1);
    check("n0_nwrites", wlog.size(),           32'd0);
    check("n0_words",   {21'b0, words_loaded}, 32'd0);
    pulse_load();
    frame = {8'h01, 8'h04, 8'h00, 8'h00};
    send_frame(0);
    check("n1025_err",     {31'b0, err}, 32'd1);
    check("n1025_nwrites", wlog.size(),  32'd0);
    pulse_load();

    // Backpressure: random rx_valid gaps on the two-word frame
    wlog.delete();
    bp_mode = 1'b1;
    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_frame(3);
    bp_mode = 1'b0;
    check("bp_done",    {31'b0, done},         32'd1);
    check("bp_words",   {21'b0, words_loaded}, 32'd2);
    check("bp_nwrites", wlog.size(),           32'd2);
    check("bp_w0_a",    wlog[0].a,             32'h0);
    check("bp_w0_d",    wlog[0].d,             32'h1234_5678);
    check("bp_w1_a",    wlog[1].a,             32'h4);
    check("bp_w1_d",    wlog[1].d,             32'hDEAD_BEEF);

    // Full-size load: word i holds byte i[7:0] in all lanes, so csum = 0
    pulse_load();
    wlog.delete();
    frame = {8'h00, 8'h04, 8'h00, 8'h00};
    send_frame(0);
    for (int i = 0; i < 1024; i++)
      repeat (4) send_byte(8'(i), 0);
    send_byte(8'h00, 0);
    check("max_done",    {31'b0, done},         32'd1);
    check("max_words",   {21'b0, words_loaded}, 32'd1024);
    check("max_nwrites", wlog.size(),           32'd1024);
    check("max_first_a", wlog[0].a,             32'h0);
    check("max_last_a",  wlog[1023].a,          32'hFFC);
    check("max_last_d",  wlog[1023].d,          32'hFFFF_FFFF);
    check("max_mid_d",   wlog[300].d,           32'h2C2C_2C2C);

    // Reset during DATA after the fifth data byte
    pulse_load();
    wlog.delete();
    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    send_frame(0);
    check("mr_nwrites", wlog.size(), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mr_core_rst_n", {31'b0, core_rst_n},   32'd0);
    check("mr_mem_we",     {31'b0, mem_we},       32'd0);
    check("mr_words",      {21'b0, words_loaded}, 32'd0);
    check("mr_busy",       {31'b0, busy},         32'd1);
    check("mr_rx_ready",   {31'b0, rif.rx_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("mr_hdr_ready", {31'b0, rif.rx_ready}, 32'd1);
    wlog.delete();
    frame = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_frame(0);
    check("mr_done",    {31'b0, done},         32'd1);
    check("mr_words2",  {21'b0, words_loaded}, 32'd2);
    check("mr_nwrites2", wlog.size(),          32'd2);
    check("mr_w0_d",    wlog[0].d,             32'h1234_5678);
    check("mr_w1_a",    wlog[1].a,             32'h4);
    check("mr_w1_d",    wlog[1].d,             32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
